// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register responder: terminates the PS control bus and exposes a
// bank of NUM_REGS word-spaced registers to the PL.
//
// Ports:
//   clk, rst              bus/register clock, asynchronous active-high reset
//   ps_axi_aw*            write address channel (awprot ignored)
//   ps_axi_w*             write data channel with byte strobes
//   ps_axi_b*             write response channel (OKAY / SLVERR)
//   ps_axi_ar*            read address channel (arprot ignored)
//   ps_axi_r*             read data channel (OKAY / SLVERR)
//   reg_out               packed read-write register contents
//   reg_in                packed read-only register sources
//   wr_pulse              one-cycle strobe per successful register write
module axi_lite_reg_responder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          ps_axi_awaddr,
    input  logic [2:0]                     ps_axi_awprot,
    input  logic                           ps_axi_awvalid,
    output logic                           ps_axi_awready,
    input  logic [DATA_WIDTH-1:0]          ps_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        ps_axi_wstrb,
    input  logic                           ps_axi_wvalid,
    output logic                           ps_axi_wready,
    output logic [1:0]                     ps_axi_bresp,
    output logic                           ps_axi_bvalid,
    input  logic                           ps_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          ps_axi_araddr,
    input  logic [2:0]                     ps_axi_arprot,
    input  logic                           ps_axi_arvalid,
    output logic                           ps_axi_arready,
    output logic [DATA_WIDTH-1:0]          ps_axi_rdata,
    output logic [1:0]                     ps_axi_rresp,
    output logic                           ps_axi_rvalid,
    input  logic                           ps_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_PART, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic aw_full, w_full;
    logic aw_ready_nxt, w_ready_nxt;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  wr_ok, rd_ok;
    logic [IDX_WIDTH-1:0]  wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic [1:0]            rd_resp_nxt;

    logic unused_prot;
    assign unused_prot = ^{ps_axi_awprot, ps_axi_arprot};

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) &&
               ((off >> 2) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_WIDTH'(off >> 2);
    endfunction

    assign aw_hs = ps_axi_awvalid && ps_axi_awready;
    assign w_hs  = ps_axi_wvalid  && ps_axi_wready;
    assign ar_hs = ps_axi_arvalid && ps_axi_arready;
    assign b_hs  = ps_axi_bvalid  && ps_axi_bready;
    assign r_hs  = ps_axi_rvalid  && ps_axi_rready;

    assign wr_ok  = addr_ok(aw_addr_q);
    assign wr_idx = addr_idx(aw_addr_q);
    assign rd_ok  = addr_ok(ps_axi_araddr);
    assign rd_idx = addr_idx(ps_axi_araddr);

    // ---------------- write FSM ----------------
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs)      w_state_nxt = W_COMMIT;
                else if (aw_hs || w_hs) w_state_nxt = W_PART;
            end
            W_PART:   if (aw_hs || w_hs) w_state_nxt = W_COMMIT;
            W_COMMIT: w_state_nxt = W_RESP;
            W_RESP:   if (b_hs) w_state_nxt = W_IDLE;
            default:  w_state_nxt = W_IDLE;
        endcase
    end

    // Readies are registered from the next state so they never follow valid
    // combinationally; in W_PART only the channel not yet held stays ready.
    always_comb begin
        aw_ready_nxt = (w_state_nxt == W_IDLE) ||
                       ((w_state_nxt == W_PART) && !(aw_full || aw_hs));
        w_ready_nxt  = (w_state_nxt == W_IDLE) ||
                       ((w_state_nxt == W_PART) && !(w_full || w_hs));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state        <= W_IDLE;
            ps_axi_awready <= 1'b0;
            ps_axi_wready  <= 1'b0;
            ps_axi_bvalid  <= 1'b0;
        end else begin
            w_state        <= w_state_nxt;
            ps_axi_awready <= aw_ready_nxt;
            ps_axi_wready  <= w_ready_nxt;
            // bvalid is registered off W_RESP, so it rises one edge after the
            // commit edge and drops on the handshake.
            ps_axi_bvalid  <= (w_state == W_RESP) && !b_hs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ps_axi_bresp <= RESP_OKAY;
            wr_pulse     <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= ps_axi_awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= ps_axi_wdata;
                w_strb_q <= ps_axi_wstrb;
            end
            if (w_state == W_COMMIT) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                if (wr_ok && !RO_MASK[wr_idx]) begin
                    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb_q[b]) regs[wr_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                    wr_pulse[wr_idx] <= 1'b1;
                    ps_axi_bresp     <= RESP_OKAY;
                end else begin
                    ps_axi_bresp <= RESP_SLVERR;
                end
            end
        end
    end

    // ---------------- read FSM ----------------
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs)  r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Reads sample regs before any same-edge commit lands (pre-write value).
    always_comb begin
        rd_data_nxt = '0;
        rd_resp_nxt = RESP_SLVERR;
        if (rd_ok) begin
            rd_resp_nxt = RESP_OKAY;
            rd_data_nxt = RO_MASK[rd_idx] ? reg_in[rd_idx*DATA_WIDTH +: DATA_WIDTH]
                                          : regs[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= R_IDLE;
            ps_axi_arready <= 1'b0;
            ps_axi_rdata   <= '0;
            ps_axi_rresp   <= RESP_OKAY;
        end else begin
            r_state        <= r_state_nxt;
            ps_axi_arready <= (r_state_nxt == R_IDLE);
            if (ar_hs) begin
                ps_axi_rdata <= rd_data_nxt;
                ps_axi_rresp <= rd_resp_nxt;
            end
        end
    end

    assign ps_axi_rvalid = (r_state == R_DATA);

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Self-checking bench for axi_lite_reg_responder: a transaction-level model
// predicts every output each cycle; directed tests add literal expectations.
module tb_axi_lite_reg_responder;

    localparam int unsigned NREG = 16;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam logic [15:0] RO   = 16'h0010;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] ps_axi_awaddr = '0;
    logic [2:0]  ps_axi_awprot = '0;
    logic        ps_axi_awvalid = 1'b0;
    logic        ps_axi_awready;
    logic [31:0] ps_axi_wdata = '0;
    logic [3:0]  ps_axi_wstrb = '0;
    logic        ps_axi_wvalid = 1'b0;
    logic        ps_axi_wready;
    logic [1:0]  ps_axi_bresp;
    logic        ps_axi_bvalid;
    logic        ps_axi_bready = 1'b0;
    logic [31:0] ps_axi_araddr = '0;
    logic [2:0]  ps_axi_arprot = '0;
    logic        ps_axi_arvalid = 1'b0;
    logic        ps_axi_arready;
    logic [31:0] ps_axi_rdata;
    logic [1:0]  ps_axi_rresp;
    logic        ps_axi_rvalid;
    logic        ps_axi_rready = 1'b0;
    logic [NREG*32-1:0] reg_out;
    logic [NREG*32-1:0] reg_in_tb = '0;
    logic [NREG-1:0]    wr_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_reg_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS(NREG),
        .BASE_ADDR(BASE),
        .RO_MASK(RO)
    ) dut (
        .clk(clk), .rst(rst),
        .ps_axi_awaddr(ps_axi_awaddr), .ps_axi_awprot(ps_axi_awprot),
        .ps_axi_awvalid(ps_axi_awvalid), .ps_axi_awready(ps_axi_awready),
        .ps_axi_wdata(ps_axi_wdata), .ps_axi_wstrb(ps_axi_wstrb),
        .ps_axi_wvalid(ps_axi_wvalid), .ps_axi_wready(ps_axi_wready),
        .ps_axi_bresp(ps_axi_bresp), .ps_axi_bvalid(ps_axi_bvalid),
        .ps_axi_bready(ps_axi_bready),
        .ps_axi_araddr(ps_axi_araddr), .ps_axi_arprot(ps_axi_arprot),
        .ps_axi_arvalid(ps_axi_arvalid), .ps_axi_arready(ps_axi_arready),
        .ps_axi_rdata(ps_axi_rdata), .ps_axi_rresp(ps_axi_rresp),
        .ps_axi_rvalid(ps_axi_rvalid), .ps_axi_rready(ps_axi_rready),
        .reg_out(reg_out), .reg_in(reg_in_tb), .wr_pulse(wr_pulse)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ra(input int unsigned i);
        return BASE + 32'(i * 4);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && ((a - BASE) / 4 < NREG);
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] m_regs [NREG];
    logic        m_awready = 0, m_wready = 0, m_arready = 0;
    logic        m_bvalid = 0, m_rvalid = 0;
    logic [1:0]  m_bresp = 0, m_rresp = 0;
    logic [31:0] m_rdata = 0;
    logic [NREG-1:0] m_pulse = 0;
    bit          m_aw_held, m_w_held, m_commit, m_b_pending, m_busy;
    logic [31:0] m_aw_addr, m_w_data;
    logic [3:0]  m_w_strb;

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0; m_pulse = 0;
        m_aw_held = 0; m_w_held = 0; m_commit = 0; m_b_pending = 0; m_busy = 0;
        m_aw_addr = 0; m_w_data = 0; m_w_strb = 0;
    endtask

    task automatic m_step();
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        int unsigned idx;
        logic [31:0] mask;
        aw_hs = ps_axi_awvalid && m_awready;
        w_hs  = ps_axi_wvalid && m_wready;
        ar_hs = ps_axi_arvalid && m_arready;
        b_hs  = m_bvalid && ps_axi_bready;
        r_hs  = m_rvalid && ps_axi_rready;
        // read sees register contents from before this edge
        if (ar_hs) begin
            if (addr_ok(ps_axi_araddr)) begin
                idx = (ps_axi_araddr - BASE) / 4;
                m_rdata = RO[idx] ? reg_in_tb[idx*32 +: 32] : m_regs[idx];
                m_rresp = 2'b00;
            end else begin
                m_rdata = 0;
                m_rresp = 2'b10;
            end
            m_rvalid = 1;
        end else if (r_hs) m_rvalid = 0;
        m_pulse = 0;
        if (m_b_pending) begin
            m_bvalid = 1; m_b_pending = 0;
        end else if (b_hs) begin
            m_bvalid = 0; m_busy = 0;
        end
        if (m_commit) begin
            m_commit = 0; m_b_pending = 1;
            idx = (m_aw_addr - BASE) / 4;
            if (addr_ok(m_aw_addr) && !RO[idx]) begin
                mask = 0;
                for (int b = 0; b < 4; b++) if (m_w_strb[b]) mask = mask | (32'hFF << (8 * b));
                m_regs[idx] = (m_regs[idx] & ~mask) | (m_w_data & mask);
                m_pulse[idx] = 1;
                m_bresp = 2'b00;
            end else m_bresp = 2'b10;
        end
        if (aw_hs) begin m_aw_held = 1; m_aw_addr = ps_axi_awaddr; end
        if (w_hs)  begin m_w_held = 1; m_w_data = ps_axi_wdata; m_w_strb = ps_axi_wstrb; end
        if (m_aw_held && m_w_held) begin
            m_aw_held = 0; m_w_held = 0; m_commit = 1; m_busy = 1;
        end
        m_awready = !m_busy && !m_aw_held;
        m_wready  = !m_busy && !m_w_held;
        m_arready = !m_rvalid;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    always @(negedge clk) begin
        check("awready", ps_axi_awready, m_awready);
        check("wready", ps_axi_wready, m_wready);
        check("arready", ps_axi_arready, m_arready);
        check("bvalid", ps_axi_bvalid, m_bvalid);
        check("rvalid", ps_axi_rvalid, m_rvalid);
        check("wr_pulse", wr_pulse, m_pulse);
        if (m_bvalid || rst) check("bresp", ps_axi_bresp, m_bresp);
        if (m_rvalid || rst) begin
            check("rdata", ps_axi_rdata, m_rdata);
            check("rresp", ps_axi_rresp, m_rresp);
        end
        for (int i = 0; i < NREG; i++) check("reg_out", reg_out[i*32 +: 32], m_regs[i]);
    end

    // ---------------- bus driver tasks ----------------
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit use_aw, input bit use_w);
        bit aw_done, w_done, aw_now, w_now;
        aw_done = !use_aw; w_done = !use_w;
        if (use_aw) begin ps_axi_awaddr = a; ps_axi_awvalid = 1; end
        if (use_w)  begin ps_axi_wdata = d; ps_axi_wstrb = s; ps_axi_wvalid = 1; end
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_now = ps_axi_awvalid && ps_axi_awready;
            w_now  = ps_axi_wvalid && ps_axi_wready;
            @(posedge clk); #1;
            if (aw_now) begin aw_done = 1; ps_axi_awvalid = 0; end
            if (w_now)  begin w_done = 1; ps_axi_wvalid = 0; end
        end
        check("write_accept", aw_done && w_done, 1);
        ps_axi_awvalid = 0; ps_axi_wvalid = 0;
    endtask

    task automatic recv_b(input int delay, output logic [1:0] resp);
        bit seen;
        seen = 0;
        ps_axi_bready = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (ps_axi_bvalid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("b_arrives", seen, 1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bvalid_hold", ps_axi_bvalid, 1);
            check("awready_bp", ps_axi_awready, 0);
            check("wready_bp", ps_axi_wready, 0);
        end
        resp = ps_axi_bresp;
        ps_axi_bready = 1;
        @(posedge clk); #1;
        ps_axi_bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int delay, output logic [31:0] d, output logic [1:0] r);
        bit acc, acc_now;
        acc = 0;
        ps_axi_araddr = a; ps_axi_arvalid = 1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc_now = ps_axi_arready;
            @(posedge clk); #1;
            if (acc_now) begin acc = 1; ps_axi_arvalid = 0; end
        end
        check("ar_accept", acc, 1);
        ps_axi_arvalid = 0;
        @(negedge clk);
        check("r_latency", ps_axi_rvalid, 1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rvalid_hold", ps_axi_rvalid, 1);
            check("arready_bp", ps_axi_arready, 0);
        end
        d = ps_axi_rdata; r = ps_axi_rresp;
        ps_axi_rready = 1;
        @(posedge clk); #1;
        ps_axi_rready = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        send_aw_w(a, d, s, 1, 1);
        recv_b(0, resp);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        for (int i = 0; i < NREG; i++) reg_in_tb[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("awready_pre_edge", ps_axi_awready, 0);
        @(posedge clk); #1;
        check("awready_rise", ps_axi_awready, 1);
        check("wready_rise", ps_axi_wready, 1);
        check("arready_rise", ps_axi_arready, 1);

        // basic write/read with latency pins
        send_aw_w(ra(2), 32'h0000_BEEF, 4'hF, 1, 1);
        @(posedge clk); #1;
        check("basic_pulse_n1", wr_pulse, 16'h0004);
        check("basic_bvalid_n1", ps_axi_bvalid, 0);
        @(posedge clk); #1;
        check("basic_pulse_n2", wr_pulse, 16'h0000);
        check("basic_bvalid_n2", ps_axi_bvalid, 1);
        recv_b(0, resp);
        check("basic_bresp", resp, 2'b00);
        do_read(ra(2), 0, rd, resp);
        check("basic_rdata", rd, 32'h0000_BEEF);
        check("basic_rresp", resp, 2'b00);

        // partial strobe
        wr(ra(3), 32'h1122_3344, 4'hF, resp);
        wr(ra(3), 32'hAABB_CCDD, 4'b0101, resp);
        check("partial_bresp", resp, 2'b00);
        do_read(ra(3), 0, rd, resp);
        check("partial_rdata", rd, 32'h11BB_33DD);
        check("partial_model", m_regs[3], 32'h11BB_33DD);

        // error cases
        wr(BASE + 32'(4 * NREG), 32'hDEAD_0001, 4'hF, resp);
        check("err_past_end", resp, 2'b10);
        wr(BASE + 32'd2, 32'hDEAD_0002, 4'hF, resp);
        check("err_unaligned", resp, 2'b10);
        wr(BASE - 32'd4, 32'hDEAD_0003, 4'hF, resp);
        check("err_below_base", resp, 2'b10);
        wr(ra(4), 32'hDEAD_0004, 4'hF, resp);
        check("err_ro_write", resp, 2'b10);
        check("err_ro_unchanged", reg_out[4*32 +: 32], 32'h0);
        do_read(BASE + 32'(4 * NREG), 0, rd, resp);
        check("err_rd_data", rd, 32'h0);
        check("err_rd_resp", resp, 2'b10);
        do_read(ra(4), 0, rd, resp);
        check("ro_rdata", rd, 32'hC0DE_0004);
        check("ro_rresp", resp, 2'b00);

        // zero strobe still pulses, no data change
        send_aw_w(ra(2), 32'h1234_5678, 4'h0, 1, 1);
        @(posedge clk); #1;
        check("zero_strb_pulse", wr_pulse, 16'h0004);
        recv_b(0, resp);
        check("zero_strb_bresp", resp, 2'b00);
        do_read(ra(2), 0, rd, resp);
        check("zero_strb_rdata", rd, 32'h0000_BEEF);

        // decoupled: W well ahead of AW
        send_aw_w(32'h0, 32'h1234_5678, 4'hF, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dec_wready_low", ps_axi_wready, 0);
            check("dec_awready_high", ps_axi_awready, 1);
            @(posedge clk); #1;
        end
        send_aw_w(ra(9), 32'h0, 4'h0, 1, 0);
        @(posedge clk); #1;
        check("dec_pulse", wr_pulse, 16'h0200);
        recv_b(0, resp);
        do_read(ra(9), 0, rd, resp);
        check("dec_rdata", rd, 32'h1234_5678);

        // B backpressure with the next write already waiting
        send_aw_w(ra(10), 32'hA0A0_A0A0, 4'hF, 1, 1);
        ps_axi_awaddr = ra(11); ps_axi_wdata = 32'hB1B1_B1B1; ps_axi_wstrb = 4'hF;
        ps_axi_awvalid = 1; ps_axi_wvalid = 1;
        recv_b(10, resp);
        check("bp_bresp", resp, 2'b00);
        check("bp_reg11_untouched", reg_out[11*32 +: 32], 32'h0);
        send_aw_w(ra(11), 32'hB1B1_B1B1, 4'hF, 1, 1);
        recv_b(0, resp);
        // R backpressure
        do_read(ra(10), 10, rd, resp);
        check("bp_rdata", rd, 32'hA0A0_A0A0);

        // read accepted on the commit edge returns the old value
        wr(ra(12), 32'h0C0C_0C0C, 4'hF, resp);
        send_aw_w(ra(12), 32'hFFFF_0000, 4'hF, 1, 1);
        do_read(ra(12), 0, rd, resp);
        check("same_edge_old", rd, 32'h0C0C_0C0C);
        recv_b(0, resp);
        do_read(ra(12), 0, rd, resp);
        check("same_edge_new", rd, 32'hFFFF_0000);

        // reset with AW held and W missing
        wr(ra(5), 32'h5555_5555, 4'hF, resp);
        send_aw_w(ra(5), 32'h0, 4'h0, 1, 0);
        @(negedge clk);
        check("rstw_awready", ps_axi_awready, 0);
        check("rstw_wready", ps_axi_wready, 1);
        #2 rst = 1;
        #1;
        check("rstw_out_awready", ps_axi_awready, 0);
        check("rstw_out_wready", ps_axi_wready, 0);
        check("rstw_out_arready", ps_axi_arready, 0);
        check("rstw_out_bvalid", ps_axi_bvalid, 0);
        check("rstw_out_rvalid", ps_axi_rvalid, 0);
        check("rstw_out_pulse", wr_pulse, 16'h0);
        check("rstw_out_regs", reg_out == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (5) @(posedge clk);
        #1;
        do_read(ra(5), 0, rd, resp);
        check("rstw_rdata", rd, 32'h0);
        check("rstw_rresp", resp, 2'b00);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
